// File: rtl/memory_stage_lsu.sv
// memory_stage_lsu: M->W pipeline register with a local data memory and a
// configurable number of wait states per access.
// Optional feature macro: MEM_STALL_CNT_EN (saturating stall-cycle counter on StallCnt).
//
// state | meaning
// IDLE  | no access in flight; zero-latency accesses complete here
// WAIT  | access held by upstream, counting down remaining wait cycles
module memory_stage_lsu #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int MEM_LATENCY = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidM,
    input  logic            RegWriteM,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic            ResultSrcM,
    input  logic [2:0]      Funct3M,
    input  logic [4:0]      RD_M,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] ALU_ResultM,
    output logic            StallM,
    output logic            ValidW,
    output logic            RegWriteW,
    output logic            ResultSrcW,
    output logic            MisalignW,
    output logic [4:0]      RD_W,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [31:0]     StallCnt
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int NB = XLEN / 8;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    logic            mem_op, aligned, misalign, access, complete, stall, mem_we;
    logic [AW-1:0]   word_idx;
    logic [1:0]      byte_off;
    logic [XLEN-1:0] rd_word, load_data, wr_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [NB-1:0]   byte_en;
    logic            unused_addr_hi;

    logic            valid_w_q, valid_w_d;
    logic            reg_write_w_q, reg_write_w_d;
    logic            result_src_w_q, result_src_w_d;
    logic            misalign_w_q, misalign_w_d;
    logic [4:0]      rd_w_q, rd_w_d;
    logic [XLEN-1:0] pc_plus4_w_q, pc_plus4_w_d;
    logic [XLEN-1:0] alu_result_w_q, alu_result_w_d;
    logic [XLEN-1:0] read_data_w_q, read_data_w_d;

    // Address wraps modulo the array depth; the upper address bits are ignored.
    assign word_idx       = ALU_ResultM[AW+1:2];
    assign byte_off       = ALU_ResultM[1:0];
    assign unused_addr_hi = ^ALU_ResultM[XLEN-1:AW+2];

    // Alignment, access qualification and store lane steering (reserved sizes act as word).
    always_comb begin
        mem_op  = MemReadM | MemWriteM;
        aligned = 1'b1;
        byte_en = '1;
        wr_word = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                byte_en = NB'(1) << byte_off;
                wr_word = {NB{WriteDataM[7:0]}};
            end
            2'b01: begin
                aligned = ~ALU_ResultM[0];
                byte_en = NB'(3) << {ALU_ResultM[1], 1'b0};
                wr_word = {(NB/2){WriteDataM[15:0]}};
            end
            default: aligned = (ALU_ResultM[1:0] == 2'b00);
        endcase
        misalign = mem_op & ~aligned;
        // Reset gates the access so a held request cannot stall or write while rst is low.
        access   = rst & ValidM & mem_op & aligned;
    end

    // Load data extraction and sign/zero extension.
    always_comb begin
        rd_word = mem_q[word_idx];
        rd_byte = rd_word[{byte_off, 3'b000} +: 8];
        rd_half = rd_word[{ALU_ResultM[1], 4'b0000} +: 16];
        case (Funct3M)
            3'b000:  load_data = {{(XLEN-8){rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{(XLEN-16){rd_half[15]}}, rd_half};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, rd_byte};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // Wait-state FSM: next state, countdown and stall/complete decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (MEM_LATENCY == 0) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = 3'(MEM_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    complete = access;
                    state_d  = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        mem_we = complete & MemWriteM;
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data array: written once at the completing edge, never touched by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (byte_en[i]) mem_q[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    // W-stage next values: bubble while stalled or when M is invalid.
    always_comb begin
        valid_w_d      = 1'b0;
        reg_write_w_d  = 1'b0;
        result_src_w_d = 1'b0;
        misalign_w_d   = 1'b0;
        rd_w_d         = 5'd0;
        pc_plus4_w_d   = '0;
        alu_result_w_d = '0;
        read_data_w_d  = '0;
        if (!stall && ValidM) begin
            valid_w_d      = 1'b1;
            reg_write_w_d  = RegWriteM & ~misalign;
            result_src_w_d = ResultSrcM;
            misalign_w_d   = misalign;
            rd_w_d         = RD_M;
            pc_plus4_w_d   = PCPlus4M;
            alu_result_w_d = ALU_ResultM;
            read_data_w_d  = (MemReadM & aligned) ? load_data : '0;
        end
    end

    // W-stage pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_w_q      <= 1'b0;
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= 1'b0;
            misalign_w_q   <= 1'b0;
            rd_w_q         <= 5'd0;
            pc_plus4_w_q   <= '0;
            alu_result_w_q <= '0;
            read_data_w_q  <= '0;
        end else begin
            valid_w_q      <= valid_w_d;
            reg_write_w_q  <= reg_write_w_d;
            result_src_w_q <= result_src_w_d;
            misalign_w_q   <= misalign_w_d;
            rd_w_q         <= rd_w_d;
            pc_plus4_w_q   <= pc_plus4_w_d;
            alu_result_w_q <= alu_result_w_d;
            read_data_w_q  <= read_data_w_d;
        end
    end

`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles with StallM asserted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= 32'd0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign StallCnt = stall_cnt_q;
`else
    assign StallCnt = 32'd0;
`endif

    assign StallM      = stall;
    assign ValidW      = valid_w_q;
    assign RegWriteW   = reg_write_w_q;
    assign ResultSrcW  = result_src_w_q;
    assign MisalignW   = misalign_w_q;
    assign RD_W        = rd_w_q;
    assign PCPlus4W    = pc_plus4_w_q;
    assign ALU_ResultW = alu_result_w_q;
    assign ReadDataW   = read_data_w_q;

endmodule
